cla4: RTL and testbench
=======================

CLA4 -- requirements
Module: cla4

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all sequential elements SHALL update on its rising edge only.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 A  input  4  addend operand, unsigned.
REQ-005 B  input  4  augend operand, unsigned.
REQ-006 Ci  input  1  carry-in.
REQ-007 S  output  4  combinational sum bits.
REQ-008 Co  output  1  combinational carry-out.
REQ-009 PG  output  1  combinational group propagate.
REQ-010 GG  output  1  combinational group generate.
REQ-011 S_r  output  4  registered copy of S.
REQ-012 Co_r  output  1  registered copy of Co.
REQ-013 PG_r  output  1  registered copy of PG.
REQ-014 GG_r  output  1  registered copy of GG.
REQ-015 vld_r  output  1  high when the registered outputs hold a result captured since reset.
REQ-016 Ports SHALL be connected by name.

Function
REQ-017 Per bit i (0..3): Pi = Ai XOR Bi and Gi = Ai AND Bi.
REQ-018 Carries SHALL be computed by look-ahead, never by ripple chaining:
- c0 = Ci
- c1 = G0 | P0c0
- c2 = G1 | P1G0 | P1P0c0
- c3 = G2 | P2G1 | P2P1G0 | P2P1P0c0
REQ-019 Si = Pi XOR ci for each bit.
REQ-020 PG = P3&P2&P1&P0.
REQ-021 GG = G3 | P3G2 | P3P2G1 | P3P2P1G0; GG SHALL NOT depend on Ci.
REQ-022 Co = GG | (PG & Ci).
REQ-023 The 5-bit value {Co,S} SHALL equal A+B+Ci for all 512 input combinations.
REQ-024 S, Co, PG and GG SHALL be purely combinational, with zero-cycle latency from A, B and Ci.
REQ-025 S, Co, PG and GG SHALL be unaffected by clk and reset.
REQ-026 PG and GG SHALL never both be 1.
REQ-027 Each rising clk edge with reset low SHALL capture {S,Co,PG,GG} into {S_r,Co_r,PG_r,GG_r}, giving one-cycle latency.
REQ-028 On each such edge, vld_r SHALL be set to 1.
REQ-029 The block SHALL have no handshake; it accepts new operands every cycle.
REQ-030 Overflow SHALL be reported only via Co; the sum SHALL wrap modulo 16.

Reset
REQ-031 On a rising clk edge with reset high: S_r=0000, Co_r=0, PG_r=0, GG_r=0 and vld_r=0.
REQ-032 Reset SHALL take priority over capture on the same edge.
REQ-033 Asserting reset mid-operation SHALL clear the registered outputs on the next edge while the combinational outputs keep tracking their inputs.
REQ-034 The first capture SHALL occur on the first rising edge with reset low.

Structure
REQ-035 A shared package SHALL hold the width constant (4) and the reset value of the registered output bundle.
REQ-036 One sub-module, cla_pg_cell, SHALL be used, instantiated 4 times; per bit it takes Ai and Bi and produces Pi and Gi.
REQ-037 Carry look-ahead logic, the sum XORs and the output register SHALL live in cla4.

Verification
REQ-038 A=0000, B=0000, Ci=0 -> S=0000, Co=0, PG=0, GG=0.
REQ-039 A=1111, B=0000, Ci=1 -> S=0000, Co=1, PG=1, GG=0.
REQ-040 A=1111, B=1111, Ci=0 -> S=1110, Co=1, PG=0, GG=1.
REQ-041 A=0101, B=0011, Ci=1 -> S=1001, Co=0, PG=0, GG=0.
REQ-042 Exhaustive sweep of all 512 (A,B,Ci) combinations -> {Co,S}=A+B+Ci, PG and GG per REQ-020/021, checked at mid-cycle after inputs settle.
REQ-043 reset high for 2 edges, then A=1000, B=1000, Ci=0 with reset low -> vld_r=0 during reset; after the next edge S_r=0000, Co_r=1, GG_r=1, PG_r=0, vld_r=1.

Source files
------------

// File: rtl/cla4_pkg.sv
// Shared constants for the 4-bit carry look-ahead adder: operand width and
// the reset value of the registered result bundle.
package cla4_pkg;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         pg;
        logic         gg;
    } cla_res_t;

    localparam cla_res_t RES_RST = '{s: '0, co: 1'b0, pg: 1'b0, gg: 1'b0};

endpackage : cla4_pkg

// File: rtl/cla_pg_cell.sv
// Per-bit propagate/generate cell for the look-ahead adder.
module cla_pg_cell (
    input  logic a_i,
    input  logic b_i,
    output logic p_o,
    output logic g_o
);

    assign p_o = a_i ^ b_i;
    assign g_o = a_i & b_i;

endmodule : cla_pg_cell

// File: rtl/cla4.sv
// 4-bit carry look-ahead adder with combinational outputs and a one-cycle
// registered copy of the result, plus a valid flag cleared by reset.
module cla4
    import cla4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic [W-1:0] S,
    output logic         Co,
    output logic         PG,
    output logic         GG,
    output logic [W-1:0] S_r,
    output logic         Co_r,
    output logic         PG_r,
    output logic         GG_r,
    output logic         vld_r
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] c;

    for (genvar i = 0; i < W; i++) begin : g_pg
        cla_pg_cell u_pg (
            .a_i (A[i]),
            .b_i (B[i]),
            .p_o (p[i]),
            .g_o (g[i])
        );
    end

    // Every carry is a flat sum of products of P/G and Ci; no carry feeds another.
    assign c[0] = Ci;
    assign c[1] = g[0] | (p[0] & Ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Ci);

    assign PG = &p;
    assign GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign Co = GG | (PG & Ci);
    assign S  = p ^ c;

    cla_res_t res_d;
    cla_res_t res_q;
    logic     vld_q;

    assign res_d = '{s: S, co: Co, pg: PG, gg: GG};

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= RES_RST;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= 1'b1;
        end
    end

    assign S_r   = res_q.s;
    assign Co_r  = res_q.co;
    assign PG_r  = res_q.pg;
    assign GG_r  = res_q.gg;
    assign vld_r = vld_q;

endmodule : cla4

// File: tb/tb_cla4.sv
// Self-checking bench for cla4: directed vectors, exhaustive sweep, random
// stream with registered-output tracking, and reset behaviour.
module tb_cla4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] A, B;
    logic       Ci;
    logic [3:0] S, S_r;
    logic       Co, PG, GG, Co_r, PG_r, GG_r, vld_r;

    int checks = 0;
    int failures = 0;

    cla4 dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Co    (Co),
        .PG    (PG),
        .GG    (GG),
        .S_r   (S_r),
        .Co_r  (Co_r),
        .PG_r  (PG_r),
        .GG_r  (GG_r),
        .vld_r (vld_r)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: {Co,S} = A+B+Ci; group generate = carry out of
    // A+B alone; group propagate = A+B equals exactly 15.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
        int sum;
        int ab;
        logic pg, gg;
        sum = int'(a) + int'(b) + int'(ci);
        ab  = int'(a) + int'(b);
        gg  = (ab >= 16);
        pg  = (ab == 15);
        model = {sum[4:0], pg, gg};
    endfunction

    task automatic test_reset();
        logic [6:0] e;
        reset = 1'b1;
        A = 4'b1000; B = 4'b1000; Ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vld_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_vld actual=%b expected=0", vld_r);
        end
        checks++;
        if ({S_r, Co_r, PG_r, GG_r} !== 7'b0) begin
            failures++;
            $display("FAIL reset_regs actual=%b expected=0000000", {S_r, Co_r, PG_r, GG_r});
        end
        e = model(A, B, Ci);
        checks++;
        if ({Co, S, PG, GG} !== e) begin
            failures++;
            $display("FAIL reset_comb actual=%b expected=%b", {Co, S, PG, GG}, e);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({S_r, Co_r, GG_r, PG_r, vld_r} !== {4'b0000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL first_capture actual S_r=%b Co_r=%b GG_r=%b PG_r=%b vld_r=%b expected 0000 1 1 0 1",
                     S_r, Co_r, GG_r, PG_r, vld_r);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b0101};
        logic [3:0] tb [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0011};
        logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] te [4] = '{7'b0_0000_00, 7'b1_0000_10, 7'b1_1110_01, 7'b0_1001_00};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            A = ta[i]; B = tb[i]; Ci = tc[i];
            #3;
            checks++;
            if ({Co, S, PG, GG} !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d actual={Co,S,PG,GG}=%b expected=%b", i, {Co, S, PG, GG}, te[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] e;
        int bad = 0;
        for (int v = 0; v < 512; v++) begin
            A = v[3:0]; B = v[7:4]; Ci = v[8];
            #2;
            e = model(A, B, Ci);
            checks++;
            if ({Co, S, PG, GG} !== e || (PG && GG)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL sweep A=%h B=%h Ci=%b actual=%b expected=%b", A, B, Ci, {Co, S, PG, GG}, e);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [6:0] exp_q;
        logic       have = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (have) begin
                checks++;
                if ({Co_r, S_r, PG_r, GG_r, vld_r} !== {exp_q, 1'b1}) begin
                    failures++;
                    $display("FAIL stream_reg n=%0d actual=%b expected=%b", n,
                             {Co_r, S_r, PG_r, GG_r, vld_r}, {exp_q, 1'b1});
                end
            end
            A = 4'($urandom); B = 4'($urandom); Ci = 1'($urandom);
            #3;
            exp_q = model(A, B, Ci);
            have = 1'b1;
            checks++;
            if ({Co, S, PG, GG} !== exp_q) begin
                failures++;
                $display("FAIL stream_comb A=%h B=%h Ci=%b actual=%b expected=%b", A, B, Ci,
                         {Co, S, PG, GG}, exp_q);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] e;
        @(posedge clk);
        #1;
        A = 4'hF; B = 4'h1; Ci = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({S_r, Co_r, PG_r, GG_r, vld_r} !== 8'b0) begin
            failures++;
            $display("FAIL midreset_regs actual=%b expected=00000000", {S_r, Co_r, PG_r, GG_r, vld_r});
        end
        A = 4'($urandom); B = 4'($urandom); Ci = 1'($urandom);
        #2;
        e = model(A, B, Ci);
        checks++;
        if ({Co, S, PG, GG} !== e) begin
            failures++;
            $display("FAIL midreset_comb actual=%b expected=%b", {Co, S, PG, GG}, e);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Co_r, S_r, PG_r, GG_r, vld_r} !== {e, 1'b1}) begin
            failures++;
            $display("FAIL midreset_recover actual=%b expected=%b", {Co_r, S_r, PG_r, GG_r, vld_r}, {e, 1'b1});
        end
    endtask

    initial begin
        reset = 1'b1;
        A = '0; B = '0; Ci = 1'b0;
        test_reset();
        test_directed();
        test_exhaustive();
        test_random_stream();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cla4
